augment_sequencer: RTL and testbench
====================================

Name: augment_sequencer

Overview:
- Scheduler for the on-chip augmentation pipeline.
- Runs the enabled augmentation stages (resized crop, rotation, etc.) one after another on one image.
- Gives each stage exclusive use of a ping-pong BRAM buffer pair and hands the result buffer back to the PS-side control.
- Sits between the PS GPIO/interrupt interface and the stages' start/done/restart pins.

Parameters:
- NUM_STAGES, 4, number of augmentation stages; stage index 0 runs first.
- TIMEOUT_CYCLES, 1048576, WAIT-state cycles allowed before a stage is declared hung.
- CNT_W, 20, timeout counter width; must satisfy 2**CNT_W >= TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_start  in  1  one-cycle request to process an image; honoured only in IDLE or ERROR.
- job_abort  in  1  level; forces the active stage to restart and returns the block to IDLE.
- stage_enable  in  NUM_STAGES  per-stage enable mask, latched on an accepted job_start.
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to a stage.
- stage_done  in  NUM_STAGES  per-stage completion pulse (image_done).
- stage_restart  out  NUM_STAGES  one-cycle restart pulse to a hung or aborted stage.
- src_buf  out  1  buffer the active stage reads.
- dst_buf  out  1  buffer the active stage writes; always ~src_buf.
- busy  out  1  high from accepted job_start until DONE, ERROR or abort completes.
- job_done  out  1  one-cycle completion pulse; doubles as the interrupt.
- result_buf  out  1  buffer holding the final image; valid when job_done pulses, held until the next accepted job.
- error  out  1  sticky timeout flag; cleared by an accepted job_start or reset.
- error_stage  out  $clog2(NUM_STAGES)  index of the stage that timed out.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE.
  - All outputs 0: stage_start, stage_restart, busy, job_done, error, error_stage, result_buf, src_buf.
  - dst_buf=1; timeout counter 0.
- States: IDLE, SCAN, START, WAIT, ADVANCE, DONE, ERROR.
- IDLE/ERROR + job_start:
  - latch stage_enable into en_q; idx=0; src_buf=0; clear error; busy=1; go to SCAN.
- SCAN (one cycle):
  - if idx < NUM_STAGES and en_q[idx]: go to START.
  - else if idx < NUM_STAGES-1: idx++ and stay in SCAN.
  - else: go to DONE.
- START: stage_start[idx]=1 for exactly this cycle; counter cleared; go to WAIT.
- WAIT:
  - stage_done[idx] goes to ADVANCE.
  - Done pulses from any other stage are ignored.
  - A done pulse in the START cycle is ignored.
  - Counter increments each cycle. When counter==TIMEOUT_CYCLES-1 without done: pulse stage_restart[idx], set error=1 and error_stage=idx, busy=0, go to ERROR.
  - If done and timeout occur in the same cycle, done wins.
- ADVANCE (one cycle):
  - toggle src_buf (the stage's output becomes the next stage's input).
  - if idx==NUM_STAGES-1: go to DONE; else idx++ and go to SCAN.
- DONE (one cycle): result_buf=src_buf; job_done=1; busy=0; go to IDLE.
- All-zero stage_enable: job_done pulses 1+NUM_STAGES+1 cycles after job_start; result_buf=0.
- Latency per enabled stage: stage_start rises 2 cycles after entry to SCAN for that idx (SCAN, then START). Overhead between one stage's done and the next stage's start: ADVANCE+SCAN+START = 3 cycles when the next stage is enabled.
- job_start while busy: ignored; no queueing.
- job_abort (any busy state):
  - next cycle: pulse stage_restart[idx] if state was START or WAIT; busy=0; go to IDLE.
  - no job_done; error unchanged.
  - abort has priority over done and timeout in the same cycle.
- Buffer selects are registered and change only in ADVANCE and on job acceptance; they are stable for the full START/WAIT of a stage.
- stage_start and stage_restart are never both high, and are at most one-hot.

Decomposition:
- Package augment_pkg:
  - state enum typedef.
  - NUM_STAGES default.
  - stage index constants STAGE_CROP=0, STAGE_ROTATE=1.
  - buffer id constants BUF_A=0, BUF_B=1.
- One sub-module, augment_watchdog: CNT_W counter with clear/enable inputs and an expired output at TIMEOUT_CYCLES-1. Shared later by the write path.
- FSM, index and buffer logic stay in augment_sequencer.

Test Plan:
- Enable=4'b0011, each stage answers done 50 cycles after start:
  - start[0] then start[1].
  - src_buf 0 for stage 0, 1 for stage 1.
  - job_done once; result_buf=0.
- Enable=4'b0101:
  - stage 1 never started.
  - stage 2 runs with src_buf=1.
  - result_buf=0 at job_done.
- Enable=4'b0000: job_done exactly 6 cycles after job_start; result_buf=0; no stage_start.
- Enable=4'b0001, stage 0 silent, TIMEOUT_CYCLES=16:
  - stage_restart[0] pulses 16 cycles after START.
  - error=1, error_stage=0, busy=0, no job_done.
  - next job_start clears error.
- Stage 0 done pulse arrives while stage 1 is active: ignored. job_start issued mid-job: ignored. Job completes normally.
- job_abort during WAIT on stage 1: stage_restart[1] pulses, IDLE next cycle, no job_done. Reset asserted mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/augment_pkg.sv
`default_nettype none
// ============================================================================
// Module      : augment_pkg
// Description : Shared types and constants for the augmentation sequencer and
//               its helpers: FSM state encoding, default stage count, stage
//               index names and ping-pong buffer identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package augment_pkg;

    // Default number of augmentation stages in the pipeline.
    localparam int c_NUM_STAGES = 4;

    // Stage index names (index 0 runs first).
    localparam int c_STAGE_CROP   = 0;
    localparam int c_STAGE_ROTATE = 1;

    // Ping-pong BRAM buffer identifiers.
    localparam logic c_BUF_A = 1'b0;
    localparam logic c_BUF_B = 1'b1;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

endpackage : augment_pkg
`default_nettype wire

// File: rtl/augment_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : augment_watchdog
// Description : Cycle counter used to detect a hung stage. Counts while
//               enabled, saturates once it reaches TIMEOUT_CYCLES-1 and
//               reports that as expired. Intended for reuse by other paths.
// Ports       : clk       - system clock
//               reset     - asynchronous active-low reset
//               i_clear   - synchronous clear to zero (wins over enable)
//               i_enable  - count one cycle
//               o_expired - counter sits at TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module augment_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 20      // 2**CNT_W must cover TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturate at the terminal value so a stalled consumer never sees the
    // counter wrap back to zero and drop the expired indication.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == c_LAST);

endmodule : augment_watchdog
`default_nettype wire

// File: rtl/augment_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : augment_sequencer
// Description : Runs the enabled augmentation stages one after another on a
//               single image, giving each exclusive use of a ping-pong buffer
//               pair and reporting the buffer that holds the final image.
//               A watchdog restarts a stage that never signals completion.
// Ports       : clk, reset          - clock, asynchronous active-low reset
//               job_start           - one-cycle job request (IDLE/ERROR only)
//               job_abort           - level abort, restarts the active stage
//               stage_enable        - stage mask, latched on job acceptance
//               stage_start         - one-hot start pulse to a stage
//               stage_done          - per-stage completion pulses
//               stage_restart       - one-hot restart pulse (hang or abort)
//               src_buf / dst_buf   - buffers read / written by active stage
//               busy, job_done      - job in flight, completion interrupt
//               result_buf          - buffer holding the final image
//               error, error_stage  - sticky timeout flag and stage index
// Revision    : 1.0 - initial release
// ============================================================================
module augment_sequencer
    import augment_pkg::*;
#(
    parameter  int NUM_STAGES     = c_NUM_STAGES,
    parameter  int TIMEOUT_CYCLES = 1048576,
    parameter  int CNT_W          = 20,
    localparam int IDX_W          = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  job_start,
    input  logic                  job_abort,
    input  logic [NUM_STAGES-1:0] stage_enable,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_restart,
    output logic                  src_buf,
    output logic                  dst_buf,
    output logic                  busy,
    output logic                  job_done,
    output logic                  result_buf,
    output logic                  error,
    output logic [IDX_W-1:0]      error_stage
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_en_q;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_stage_start;
    logic [NUM_STAGES-1:0] r_stage_restart;
    logic                  r_src_buf;
    logic                  r_busy;
    logic                  r_job_done;
    logic                  r_result_buf;
    logic                  r_error;
    logic [IDX_W-1:0]      r_error_stage;

    logic [NUM_STAGES-1:0] w_idx_onehot;
    logic                  w_active;
    logic                  w_expired;

    always_comb begin
        w_idx_onehot        = '0;
        w_idx_onehot[r_idx] = 1'b1;
    end

    // Every state other than IDLE and ERROR belongs to a job in flight.
    assign w_active = (r_state != S_IDLE) && (r_state != S_ERROR);

    // Counter restarts in START so the first WAIT cycle sees zero.
    augment_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == S_START),
        .i_enable  (r_state == S_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_en_q          <= '0;
            r_idx           <= '0;
            r_stage_start   <= '0;
            r_stage_restart <= '0;
            r_src_buf       <= c_BUF_A;
            r_busy          <= 1'b0;
            r_job_done      <= 1'b0;
            r_result_buf    <= 1'b0;
            r_error         <= 1'b0;
            r_error_stage   <= '0;
        end else begin
            // Pulse outputs default low; states below raise them for a cycle.
            r_stage_start   <= '0;
            r_stage_restart <= '0;
            r_job_done      <= 1'b0;

            if (job_abort && w_active) begin
                // Abort outranks a same-cycle done or timeout. Only a stage
                // that has been (or is being) started needs a restart.
                if (r_state == S_START || r_state == S_WAIT) begin
                    r_stage_restart <= w_idx_onehot;
                end
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (job_start) begin
                            r_en_q    <= stage_enable;
                            r_idx     <= '0;
                            r_src_buf <= c_BUF_A;
                            r_error   <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (r_en_q[r_idx]) begin
                            r_state <= S_START;
                        end else if (r_idx != c_LAST_IDX) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                    S_START: begin
                        r_stage_start <= w_idx_onehot;
                        r_state       <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Done from the active stage beats a same-cycle expiry.
                        if (stage_done[r_idx]) begin
                            r_state <= S_ADVANCE;
                        end else if (w_expired) begin
                            r_stage_restart <= w_idx_onehot;
                            r_error         <= 1'b1;
                            r_error_stage   <= r_idx;
                            r_busy          <= 1'b0;
                            r_state         <= S_ERROR;
                        end
                    end
                    S_ADVANCE: begin
                        // The finished stage's output buffer feeds the next one.
                        r_src_buf <= ~r_src_buf;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_SCAN;
                        end
                    end
                    S_DONE: begin
                        r_result_buf <= r_src_buf;
                        r_job_done   <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign stage_start   = r_stage_start;
    assign stage_restart = r_stage_restart;
    assign src_buf       = r_src_buf;
    assign dst_buf       = ~r_src_buf;
    assign busy          = r_busy;
    assign job_done      = r_job_done;
    assign result_buf    = r_result_buf;
    assign error         = r_error;
    assign error_stage   = r_error_stage;

endmodule : augment_sequencer
`default_nettype wire

// File: tb/tb_augment_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_augment_sequencer
// Description : Self-checking bench for augment_sequencer. A job-level model
//               derives, from each enable mask and per-stage response latency,
//               the cycle every stage is started, when the job ends, how the
//               buffers flip and what the final result/error is. Table vectors
//               carry hand-derived end results; random jobs add stray done
//               pulses, ignored job_start requests and aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_augment_sequencer;

    localparam int NS     = 4;
    localparam int TO     = 16;   // watchdog window used by this bench
    localparam int SILENT = 99;   // latency meaning "stage never answers"
    localparam int N_TBL  = 10;
    localparam int N_RAND = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          job_start = 1'b0;
    logic          job_abort = 1'b0;
    logic [NS-1:0] stage_enable = '0;
    logic [NS-1:0] stage_done = '0;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] stage_restart;
    logic          src_buf, dst_buf, busy, job_done, result_buf, error;
    logic [1:0]    error_stage;

    always #5 clk = ~clk;

    augment_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .job_start     (job_start),
        .job_abort     (job_abort),
        .stage_enable  (stage_enable),
        .stage_start   (stage_start),
        .stage_done    (stage_done),
        .stage_restart (stage_restart),
        .src_buf       (src_buf),
        .dst_buf       (dst_buf),
        .busy          (busy),
        .job_done      (job_done),
        .result_buf    (result_buf),
        .error         (error),
        .error_stage   (error_stage)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- job-level reference model ----------------
    // Cycle k counts from the job_start cycle (k=0); outputs seen in cycle k.
    int m_st  [NS];   // cycle stage_start[i] is seen (0 = never)
    int m_ss  [NS];   // cycle the START phase of stage i occupies
    int m_whi [NS];   // last cycle stage i can be waited on
    int m_dn  [NS];   // accepted done cycle whose buffer flip takes effect
    int m_end, m_rst_idx, m_err_stage;
    bit m_jd, m_res, m_err, m_rst_valid;
    bit e_res = 1'b0; // result_buf expected between jobs

    task automatic model(input logic [NS-1:0] en, input int lat [NS], input int ab);
        int cur = 1;
        int n   = 0;
        m_end = 0; m_jd = 0; m_res = 0; m_err = 0; m_rst_valid = 0;
        m_rst_idx = 0; m_err_stage = 0;
        for (int i = 0; i < NS; i++) begin
            m_st[i] = 0; m_ss[i] = 0; m_whi[i] = -1; m_dn[i] = 0;
        end
        // Each stage costs one look-up cycle; an enabled one adds start,
        // its response time and the hand-over cycle.
        for (int i = 0; i < NS && m_end == 0; i++) begin
            if (en[i]) begin
                m_ss[i] = cur + 1;
                m_st[i] = cur + 2;
                if (lat[i] < TO) begin
                    m_dn[i]  = cur + 2 + lat[i];
                    m_whi[i] = m_dn[i];
                    cur      = m_dn[i] + 2;
                    n++;
                end else begin
                    m_whi[i]    = cur + 2 + TO - 1;
                    m_end       = m_whi[i] + 1;
                    m_rst_valid = 1; m_rst_idx = i;
                    m_err       = 1; m_err_stage = i;
                end
            end else begin
                cur++;
            end
        end
        if (m_end == 0) begin
            m_end = cur + 1;
            m_jd  = 1;
            m_res = n[0];
        end
        if (ab > 0 && ab < m_end) begin
            m_end = ab + 1; m_jd = 0; m_err = 0; m_rst_valid = 0;
            for (int i = 0; i < NS; i++) begin
                if (m_st[i] > ab) m_st[i] = 0;
                if (m_ss[i] != 0 && ab >= m_ss[i] && ab <= m_whi[i]) begin
                    m_rst_valid = 1; m_rst_idx = i;
                end
                if (m_dn[i] != 0 && m_dn[i] + 1 >= ab) m_dn[i] = 0;
            end
        end
    endtask

    // Runs one job: drives job_start, answers stage_start pulses after the
    // given latency, optionally injects noise, and checks every cycle.
    task automatic run_job(input logic [NS-1:0] en, input int lat [NS], input int ab,
                           input bit spur, output int obs_end, output bit obs_jd,
                           output bit obs_res);
        int due [NS];
        int cnt, j;
        logic [NS-1:0] exp_start, exp_rst;
        bit exp_err, exp_res;
        model(en, lat, ab);
        obs_end = 0; obs_jd = 0; obs_res = 0;
        for (int i = 0; i < NS; i++) due[i] = -1;
        @(negedge clk);
        job_start = 1'b1; job_abort = 1'b0; stage_done = '0; stage_enable = en;
        for (int k = 1; k <= m_end + 2; k++) begin
            @(negedge clk);
            exp_start = '0; exp_rst = '0; cnt = 0;
            for (int i = 0; i < NS; i++) begin
                if (m_st[i] == k) exp_start[i] = 1'b1;
                if (m_dn[i] != 0 && m_dn[i] + 2 <= k) cnt++;
            end
            if (k == m_end && m_rst_valid) exp_rst[m_rst_idx] = 1'b1;
            exp_err = (k >= m_end) ? m_err : 1'b0;
            exp_res = (k >= m_end && m_jd) ? m_res : e_res;
            check("stage_start", stage_start, exp_start);
            check("stage_restart", stage_restart, exp_rst);
            check("job_done", job_done, (k == m_end && m_jd) ? 1 : 0);
            check("busy", busy, (k < m_end) ? 1 : 0);
            check("error", error, exp_err);
            if (exp_err) check("error_stage", error_stage, m_err_stage);
            check("src_buf", src_buf, cnt % 2);
            check("dst_buf", dst_buf, 1 - (cnt % 2));
            check("result_buf", result_buf, exp_res);
            if (!busy && obs_end == 0) obs_end = k;
            if (job_done) begin obs_jd = 1; obs_res = result_buf; end
            // stimulus for the edge closing cycle k
            job_start = 1'b0; job_abort = 1'b0; stage_done = '0;
            stage_enable = NS'($urandom);
            for (int i = 0; i < NS; i++) begin
                if (stage_start[i]) due[i] = k + lat[i];
                if (due[i] == k) stage_done[i] = 1'b1;
            end
            if (k == ab) job_abort = 1'b1;
            if (spur && k < m_end) begin
                if ($urandom_range(0, 5) == 0) job_start = 1'b1;
                j = $urandom_range(0, NS - 1);
                // never fake a done for the stage actually being waited on
                if (!(m_ss[j] != 0 && k > m_ss[j] && k <= m_whi[j]) &&
                    $urandom_range(0, 2) == 0) stage_done[j] = 1'b1;
            end
        end
        if (m_jd) e_res = m_res;
        job_start = 1'b0; job_abort = 1'b0; stage_done = '0; stage_enable = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " stage_start"}, stage_start, 0);
        check({tag, " stage_restart"}, stage_restart, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " job_done"}, job_done, 0);
        check({tag, " error"}, error, 0);
        check({tag, " error_stage"}, error_stage, 0);
        check({tag, " result_buf"}, result_buf, 0);
        check({tag, " src_buf"}, src_buf, 0);
        check({tag, " dst_buf"}, dst_buf, 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [NS-1:0] en;
        int            lat [NS];
        int            ab;
        bit            spur;
        int            exp_end;
        bit            exp_jd;
        bit            exp_res;
        bit            exp_err;
        int            exp_stage;
    } vec_t;

    vec_t tbl [N_TBL];

    task automatic set_vec(input int t, input logic [NS-1:0] en, input int l0, input int l1,
                           input int l2, input int l3, input int ab, input bit spur,
                           input int ee, input bit ejd, input bit eres, input bit eerr,
                           input int estg);
        tbl[t].en = en;
        tbl[t].lat[0] = l0; tbl[t].lat[1] = l1; tbl[t].lat[2] = l2; tbl[t].lat[3] = l3;
        tbl[t].ab = ab; tbl[t].spur = spur; tbl[t].exp_end = ee; tbl[t].exp_jd = ejd;
        tbl[t].exp_res = eres; tbl[t].exp_err = eerr; tbl[t].exp_stage = estg;
    endtask

    initial begin
        int            obs_end;
        bit            obs_jd, obs_res;
        int            rl [NS];
        logic [NS-1:0] ren;
        int            rab;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;

        // Stages answer well inside the 16-cycle watchdog window.
        //           en       l0      l1  l2  l3  ab spur end jd res err stg
        set_vec(0, 4'b0011, 10,     10,  0,  0,  0, 0,  32, 1, 0,  0,  0);
        set_vec(1, 4'b0101, 10,     10, 10, 10,  0, 0,  32, 1, 0,  0,  0);
        set_vec(2, 4'b0000,  0,      0,  0,  0,  0, 0,   6, 1, 0,  0,  0);
        set_vec(3, 4'b0001, SILENT,  0,  0,  0,  0, 0,  19, 0, 0,  1,  0);
        set_vec(4, 4'b0010,  0,      0,  0,  0,  0, 0,   9, 1, 1,  0,  0);
        set_vec(5, 4'b0111,  0,      5, 15,  0,  0, 0,  35, 1, 1,  0,  0);
        set_vec(6, 4'b1000,  0,      0,  0, 16,  0, 0,  22, 0, 0,  1,  3);
        set_vec(7, 4'b0011, 10,     10,  0,  0, 20, 0,  21, 0, 0,  0,  0);
        set_vec(8, 4'b0011, 10,     10,  0,  0,  0, 1,  32, 1, 0,  0,  0);
        set_vec(9, 4'b0001,  0,      0,  0,  0,  0, 0,   9, 1, 1,  0,  0);

        for (int t = 0; t < N_TBL; t++) begin
            run_job(tbl[t].en, tbl[t].lat, tbl[t].ab, tbl[t].spur, obs_end, obs_jd, obs_res);
            check($sformatf("vec%0d end_cycle", t), obs_end, tbl[t].exp_end);
            check($sformatf("vec%0d job_done_seen", t), obs_jd, tbl[t].exp_jd);
            if (tbl[t].exp_jd) check($sformatf("vec%0d result_buf", t), obs_res, tbl[t].exp_res);
            check($sformatf("vec%0d error", t), error, tbl[t].exp_err);
            if (tbl[t].exp_err) check($sformatf("vec%0d error_stage", t), error_stage, tbl[t].exp_stage);
        end

        // Randomised jobs with noise, late/absent responses and aborts.
        for (int r = 0; r < N_RAND; r++) begin
            ren = NS'($urandom);
            for (int i = 0; i < NS; i++) rl[i] = $urandom_range(0, 17);
            model(ren, rl, 0);
            rab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, m_end - 1) : 0;
            run_job(ren, rl, rab, 1'b1, obs_end, obs_jd, obs_res);
        end

        // Reset asserted while stage 0 is being waited on.
        @(negedge clk);
        stage_enable = 4'b0001; job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0; stage_enable = '0;
        repeat (6) @(negedge clk);
        check("busy before reset", busy, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        reset = 1'b1;
        e_res = 1'b0;
        for (int i = 0; i < NS; i++) rl[i] = 0;
        run_job(4'b0000, rl, 0, 1'b0, obs_end, obs_jd, obs_res);
        check("post-reset end_cycle", obs_end, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_augment_sequencer
`default_nettype wire
